// File: rtl/pu_riscv_ahb4_pkg.sv
// Shared AHB4-Lite encodings and the responder FSM state type.
package pu_riscv_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        AHB_IDLE = 2'd0,
        AHB_WAIT = 2'd1,
        AHB_ERR1 = 2'd2,
        AHB_ERR2 = 2'd3
    } ahb_slv_state_t;

endpackage

// File: rtl/pu_riscv_ram_1r1w.sv
// One-read one-write RAM with byte write enables and registered read data.
// A read and a write to the same word on the same edge return the old contents.
module pu_riscv_ram_1r1w #(
    parameter int DEPTH = 16384,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [WIDTH/8-1:0]       i_be,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // Byte-lane writes and synchronous read; read output holds between reads.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/pu_riscv_ahb4_slave_ram.sv
// AHB4-Lite responder backed by on-chip RAM: address decode and error checks,
// programmable wait states, two-cycle ERROR response, and a one-deep pending
// write buffer whose bytes are forwarded into reads that hit the same word.
module pu_riscv_ahb4_slave_ram
    import pu_riscv_ahb4_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              PLEN        = 32,
    parameter int              MEM_BYTES   = 65536,
    parameter logic [PLEN-1:0] BASE_ADDR   = 'h8000_0000,
    parameter int              WAIT_STATES = 0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP
);

    localparam int         NB    = XLEN / 8;
    localparam int         BL    = $clog2(NB);
    localparam int         DEPTH = MEM_BYTES / NB;
    localparam int         IW    = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    // Byte lanes covered by a transfer of the given size at the given lane offset.
    function automatic logic [NB-1:0] f_strobe(input logic [2:0] size, input logic [BL-1:0] lo);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << int'(size))) m[i] = 1'b1;
        end
        return m << lo;
    endfunction

    // Any low address bit below the transfer size being set is a misalignment.
    function automatic logic f_misaligned(input logic [2:0] size, input logic [BL-1:0] lo);
        logic r;
        r = 1'b0;
        for (int i = 0; i < BL; i++) begin
            if (i < int'(size) && lo[i]) r = 1'b1;
        end
        return r;
    endfunction

    // Strobed lanes taken from ovr, the remaining lanes from base.
    function automatic logic [XLEN-1:0] f_merge(input logic [XLEN-1:0] base,
                                                input logic [XLEN-1:0] ovr,
                                                input logic [NB-1:0]   be);
        logic [XLEN-1:0] r;
        for (int b = 0; b < NB; b++) begin
            r[b*8 +: 8] = be[b] ? ovr[b*8 +: 8] : base[b*8 +: 8];
        end
        return r;
    endfunction

    ahb_slv_state_t  r_state;
    ahb_slv_state_t  w_state_nxt;
    logic [3:0]      r_cnt;

    logic            w_ready;
    logic            w_acc;
    logic            w_err;
    logic            w_acc_ok;
    logic            w_acc_err;
    logic            w_in_range;
    logic            w_size_err;
    logic            w_misalign;
    logic            w_wr_done;
    logic            w_rd_issue;
    logic [PLEN-1:0] w_off;
    logic [IW-1:0]   w_idx;
    logic [NB-1:0]   w_be;

    logic            r_dp_wr;
    logic [IW-1:0]   r_dp_idx;
    logic [NB-1:0]   r_dp_be;

    logic            r_pend_vld;
    logic [IW-1:0]   r_pend_idx;
    logic [NB-1:0]   r_pend_be;
    logic [XLEN-1:0] r_pend_data;

    logic            r_rd_vld;
    logic [NB-1:0]   r_fwd_be;
    logic [XLEN-1:0] r_fwd_data;
    logic [NB-1:0]   w_fwd_be;
    logic [XLEN-1:0] w_fwd_data;
    logic [XLEN-1:0] w_ram_q;

    logic            w_unused;

    // Burst, protection, lock and the SEQ/NONSEQ distinction do not affect a RAM beat.
    assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Address decode and error checks on the address phase.
    assign w_off      = HADDR - BASE_ADDR;
    assign w_in_range = (HADDR >= BASE_ADDR) && (w_off < PLEN'(MEM_BYTES));
    assign w_size_err = HSIZE > 3'(BL);
    assign w_misalign = f_misaligned(HSIZE, w_off[BL-1:0]);
    assign w_err      = !w_in_range || w_size_err || w_misalign;
    assign w_idx      = w_off[BL +: IW];
    assign w_be       = f_strobe(HSIZE, w_off[BL-1:0]);

    // Data phase is stalled in ERR1 and while wait states remain.
    assign w_ready    = !(r_state == AHB_ERR1) && !(r_state == AHB_WAIT && r_cnt != 4'd0);
    assign w_acc      = HSEL && HREADY && HTRANS[1] && w_ready;
    assign w_acc_ok   = w_acc && !w_err;
    assign w_acc_err  = w_acc && w_err;
    assign w_wr_done  = r_dp_wr && w_ready;
    assign w_rd_issue = w_acc_ok && !HWRITE;

    assign HREADYOUT  = w_ready;
    assign HRESP      = (r_state == AHB_ERR1 || r_state == AHB_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA     = r_rd_vld ? f_merge(w_ram_q, r_fwd_data, r_fwd_be) : '0;

    // Next-state decode: a new transfer may start whenever the current data phase completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AHB_ERR1: w_state_nxt = AHB_ERR2;
            default: begin
                if (w_ready) begin
                    if (w_acc_err)                  w_state_nxt = AHB_ERR1;
                    else if (w_acc_ok && WS != 4'd0) w_state_nxt = AHB_WAIT;
                    else                            w_state_nxt = AHB_IDLE;
                end
            end
        endcase
    end

    // Bytes a read must take from writes not yet visible in the RAM read port:
    // the write completing this edge wins over the one committing this edge.
    always_comb begin
        w_fwd_be   = '0;
        w_fwd_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (w_wr_done && r_dp_idx == w_idx && r_dp_be[b]) begin
                w_fwd_be[b]          = 1'b1;
                w_fwd_data[b*8 +: 8] = HWDATA[b*8 +: 8];
            end else if (r_pend_vld && r_pend_idx == w_idx && r_pend_be[b]) begin
                w_fwd_be[b]          = 1'b1;
                w_fwd_data[b*8 +: 8] = r_pend_data[b*8 +: 8];
            end
        end
    end

    // Control state: FSM, wait counter, write data phase, pending write and read-valid flags.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= AHB_IDLE;
            r_cnt      <= 4'd0;
            r_dp_wr    <= 1'b0;
            r_pend_vld <= 1'b0;
            r_rd_vld   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if (w_acc_ok)            r_cnt <= WS;
            else if (r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
            if (w_ready)             r_dp_wr <= w_acc_ok && HWRITE;
            r_pend_vld <= w_wr_done;
            if (w_rd_issue)          r_rd_vld <= 1'b1;
        end
    end

    // Datapath captures: write target at accept, write data at completion, forward bytes at read issue.
    always_ff @(posedge HCLK) begin
        if (w_acc_ok) begin
            r_dp_idx <= w_idx;
            r_dp_be  <= w_be;
        end
        if (w_wr_done) begin
            r_pend_idx  <= r_dp_idx;
            r_pend_be   <= r_dp_be;
            r_pend_data <= HWDATA;
        end
        if (w_rd_issue) begin
            r_fwd_be   <= w_fwd_be;
            r_fwd_data <= w_fwd_data;
        end
    end

    pu_riscv_ram_1r1w #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_ram (
        .clk     (HCLK),
        .i_we    (r_pend_vld && !HRESET),
        .i_be    (r_pend_be),
        .i_waddr (r_pend_idx),
        .i_wdata (r_pend_data),
        .i_re    (w_rd_issue),
        .i_raddr (w_idx),
        .o_rdata (w_ram_q)
    );

endmodule

// File: tb/tb_pu_riscv_ahb4_slave_ram.sv
// Directed bench: two responders on one bus, one with no wait states and one
// with three, selected by sel; HREADY is fed back from the selected responder.
module tb_pu_riscv_ahb4_slave_ram;
    import pu_riscv_ahb4_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic        sel;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;

    logic        hsel0, hsel3, hready;
    logic        ro0, ro3, resp0, resp3, bus_resp;
    logic [31:0] rdata0, rdata3, bus_rdata;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] rd;
    int          ws;
    logic        er;

    assign hsel0     = HSEL & ~sel;
    assign hsel3     = HSEL & sel;
    assign hready    = sel ? ro3 : ro0;
    assign bus_resp  = sel ? resp3 : resp0;
    assign bus_rdata = sel ? rdata3 : rdata0;

    always #5 HCLK = ~HCLK;

    pu_riscv_ahb4_slave_ram #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata0), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(hready), .HREADYOUT(ro0), .HRESP(resp0)
    );

    pu_riscv_ahb4_slave_ram #(.WAIT_STATES(3)) u_dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata3), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(hready), .HREADYOUT(ro3), .HRESP(resp3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    // One complete transfer: address phase, then wait out the data phase.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int waits, output logic err);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = addr; HSIZE = size;
        tick;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = wdata;
        waits = 0;
        err   = 1'b0;
        while (hready !== 1'b1 && waits < 50) begin
            if (bus_resp) err = 1'b1;
            tick;
            waits++;
        end
        chk({tag, "_tmo"}, 64'(waits >= 50), 64'd0);
        rdata = bus_rdata;
        if (bus_resp) err = 1'b1;
        tick;
    endtask

    // Erroneous transfer: expect ERROR with a stall, then ERROR with ready, then idle OKAY.
    task automatic err_probe(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [2:0] size);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = addr; HSIZE = size;
        tick;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'hFFFF_FFFF;
        chk({tag, "_e1_resp"}, 64'(bus_resp), 64'd1);
        chk({tag, "_e1_rdy"},  64'(hready),   64'd0);
        tick;
        chk({tag, "_e2_resp"}, 64'(bus_resp), 64'd1);
        chk({tag, "_e2_rdy"},  64'(hready),   64'd1);
        tick;
        chk({tag, "_idle_resp"}, 64'(bus_resp), 64'd0);
        chk({tag, "_idle_rdy"},  64'(hready),   64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; sel = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HBURST = 3'd0; HPROT = 4'b0011; HTRANS = HTRANS_IDLE; HMASTLOCK = 1'b0;

        // Reset values
        tick;
        tick;
        HRESET = 1'b0;
        chk("rst_rdy0",  64'(ro0),    64'd1);
        chk("rst_resp0", 64'(resp0),  64'd0);
        chk("rst_rdat0", 64'(rdata0), 64'd0);
        chk("rst_rdy3",  64'(ro3),    64'd1);
        chk("rst_resp3", 64'(resp3),  64'd0);
        chk("rst_rdat3", 64'(rdata3), 64'd0);

        // Pipelined write then read of the same word, zero wait states
        sel = 1'b0;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h8000_0010; HSIZE = HSIZE_WORD;
        tick;
        HWDATA = 32'hDEAD_BEEF; HWRITE = 1'b0;
        chk("t2_wr_rdy", 64'(hready), 64'd1);
        tick;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        chk("t2_rd_rdy",  64'(hready),    64'd1);
        chk("t2_rd_resp", 64'(bus_resp),  64'd0);
        chk("t2_rd_data", 64'(bus_rdata), 64'hDEAD_BEEF);
        tick;
        chk("t2_hold", 64'(bus_rdata), 64'hDEAD_BEEF);
        xfer("t2_reread", 1'b0, 32'h8000_0010, HSIZE_WORD, 32'h0, rd, ws, er);
        chk("t2_reread_data", 64'(rd), 64'hDEAD_BEEF);

        // Byte write over an existing word
        xfer("t3_wrw", 1'b1, 32'h8000_0010, HSIZE_WORD, 32'h1122_3344, rd, ws, er);
        xfer("t3_wrb", 1'b1, 32'h8000_0013, HSIZE_BYTE, 32'hAA55_6677, rd, ws, er);
        xfer("t3_rd",  1'b0, 32'h8000_0010, HSIZE_WORD, 32'h0, rd, ws, er);
        chk("t3_rd_data", 64'(rd), 64'hAA22_3344);
        chk("t3_rd_err",  64'(er), 64'd0);

        // Last word of the RAM is in range
        xfer("t3_top_wr", 1'b1, 32'h8000_FFFC, HSIZE_WORD, 32'hA5A5_5A5A, rd, ws, er);
        chk("t3_top_wr_err", 64'(er), 64'd0);
        xfer("t3_top_rd", 1'b0, 32'h8000_FFFC, HSIZE_WORD, 32'h0, rd, ws, er);
        chk("t3_top_rd_data", 64'(rd), 64'hA5A5_5A5A);

        // Error responses: out of range below and above, misaligned, oversize
        err_probe("t5_low",   1'b0, 32'h0000_0000, HSIZE_WORD);
        err_probe("t5_align", 1'b0, 32'h8000_0002, HSIZE_WORD);
        err_probe("t5_high",  1'b0, 32'h8001_0000, HSIZE_WORD);
        err_probe("t5_size",  1'b0, 32'h8000_0000, HSIZE_DWORD);
        err_probe("t5_wrmis", 1'b1, 32'h8000_0011, HSIZE_HWORD);
        xfer("t5_chk", 1'b0, 32'h8000_0010, HSIZE_WORD, 32'h0, rd, ws, er);
        chk("t5_ram_untouched", 64'(rd), 64'hAA22_3344);

        // Three wait states
        sel = 1'b1;
        xfer("t4_wr", 1'b1, 32'h8000_0020, HSIZE_WORD, 32'h1234_5678, rd, ws, er);
        chk("t4_wr_waits", 64'(ws), 64'd3);
        xfer("t4_rd", 1'b0, 32'h8000_0020, HSIZE_WORD, 32'h0, rd, ws, er);
        chk("t4_rd_waits", 64'(ws), 64'd3);
        chk("t4_rd_data",  64'(rd), 64'h1234_5678);

        // Reset during the wait states of a write aborts it
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h8000_0020; HSIZE = HSIZE_WORD;
        tick;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'hCAFE_F00D;
        chk("t6_in_wait", 64'(hready), 64'd0);
        tick;
        HRESET = 1'b1;
        tick;
        HRESET = 1'b0;
        chk("t6_rst_rdy",  64'(hready),    64'd1);
        chk("t6_rst_resp", 64'(bus_resp),  64'd0);
        chk("t6_rst_rdat", 64'(bus_rdata), 64'd0);
        xfer("t6_rd", 1'b0, 32'h8000_0020, HSIZE_WORD, 32'h0, rd, ws, er);
        chk("t6_rd_data", 64'(rd), 64'h1234_5678);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
